// File: rtl/ifid_pkg.sv
// Shared types and defaults for the IF/ID skid register.
package ifid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ifid_state_e;

  localparam int unsigned INST_W_DEF   = 32;
  localparam int unsigned PC_W_DEF     = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W_DEF-1:0] inst;
    logic [PC_W_DEF-1:0]   pcplusfour;
  } ifid_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register: valid/ready handshake, one-entry skid buffer,
// synchronous flush to a NOP bubble and a saturating bubble-cycle counter.
module ifid_skid_reg
  import ifid_pkg::*;
#(
  parameter int unsigned          INST_W   = 32,
  parameter int unsigned          PC_W     = 32,
  parameter logic [INST_W-1:0]    NOP_INST = INST_W'(NOP_INST_DEF),
  parameter int unsigned          CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pcplusfour,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pcplusfour,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pcplusfour;
  } entry_t;

  ifid_state_e r_state, w_state_nxt;
  entry_t      r_main, r_skid, w_main_nxt, w_skid_nxt, w_in_entry;
  logic        w_acc, w_pop;

  assign w_in_entry = '{inst: in_inst, pcplusfour: in_pcplusfour};
  assign w_acc      = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // Entries are only invalidated; main payload keeps out_pcplusfour stable.
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = w_in_entry;
          end
        end
        ST_ONE: begin
          if (w_acc && w_pop) begin
            w_main_nxt = w_in_entry;
          end else if (w_acc) begin
            w_state_nxt = ST_TWO;
            w_skid_nxt  = w_in_entry;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // Ready depends only on registered state, never on out_ready.
  assign in_ready       = (r_state != ST_TWO);
  assign out_valid      = (r_state != ST_EMPTY);
  assign out_inst       = out_valid ? r_main.inst : NOP_INST;
  assign out_pcplusfour = r_main.pcplusfour;

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_inc   (~out_valid),
    .o_count (bubble_cnt)
  );

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Scoreboard bench for ifid_skid_reg: directed stimulus pushes expected words,
// a negedge monitor pops and compares whatever decode consumes.
module tb_ifid_skid_reg;
  import ifid_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst_n, in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] in_inst, in_pcplusfour, out_inst, out_pcplusfour;
  logic [15:0] bubble_cnt;

  logic        rst2_n, ready2, valid2;
  logic [31:0] inst2, pc2;
  logic [3:0]  cnt2;

  ifid_entry_t exp_q[$];
  ifid_entry_t mon_e;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 Clk = ~Clk;

  ifid_skid_reg dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_inst        (in_inst),
    .in_pcplusfour  (in_pcplusfour),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pcplusfour (out_pcplusfour),
    .flush          (flush),
    .bubble_cnt     (bubble_cnt)
  );

  ifid_skid_reg #(
    .CNT_W(4)
  ) dut_sat (
    .Clk            (Clk),
    .Rst_n          (rst2_n),
    .in_valid       (1'b0),
    .in_ready       (ready2),
    .in_inst        (32'h0),
    .in_pcplusfour  (32'h0),
    .out_valid      (valid2),
    .out_ready      (1'b0),
    .out_inst       (inst2),
    .out_pcplusfour (pc2),
    .flush          (1'b0),
    .bubble_cnt     (cnt2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Caller guarantees the word is accepted on the next edge.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    in_valid      = 1'b1;
    in_inst       = inst;
    in_pcplusfour = pc;
    exp_q.push_back('{inst: inst, pcplusfour: pc});
  endtask

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got %0h expected no word", out_inst);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_out_inst", {32'h0, out_inst}, {32'h0, mon_e.inst});
          chk("sb_out_pc", {32'h0, out_pcplusfour}, {32'h0, mon_e.pcplusfour});
        end
      end else if (!out_valid) begin
        chk("nop_when_invalid", {32'h0, out_inst}, {32'h0, NOP});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stream [4];
    stream[0] = 32'h1111_1111;
    stream[1] = 32'h2222_2222;
    stream[2] = 32'h3333_3333;
    stream[3] = 32'h4444_4444;

    Rst_n = 1'b0; rst2_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pcplusfour = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (3) tick();

    // Saturation on the 4-bit instance.
    rst2_n = 1'b1;
    repeat (14) tick();
    chk("sat_cnt_14", 64'(cnt2), 64'd14);
    repeat (6) tick();
    chk("sat_cnt_20", 64'(cnt2), 64'd15);
    chk("sat_valid", 64'(valid2), 64'd0);
    chk("sat_ready", 64'(ready2), 64'd1);
    chk("sat_inst", 64'(inst2), 64'(NOP));
    chk("sat_pc", 64'(pc2), 64'd0);

    // Reset values after release.
    Rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'(NOP));
    chk("rst_out_pc", 64'(out_pcplusfour), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);

    // Full-throughput stream.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(stream[i], 32'h1004 + 32'(4 * i));
      tick();
      chk("stream_latency", 64'(out_inst), 64'(stream[i]));
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(out_valid), 64'd0);
    chk("stream_bubble", 64'(bubble_cnt), 64'd1);

    // Back-pressure into the skid entry, then drain.
    out_ready = 1'b0;
    send(32'hAAAA_0001, 32'h2004);
    tick();
    chk("bp_main_a", 64'(out_inst), 64'hAAAA_0001);
    chk("bp_ready_one", 64'(in_ready), 64'd1);
    send(32'hBBBB_0002, 32'h2008);
    tick();
    in_valid = 1'b0;
    chk("bp_ready_two", 64'(in_ready), 64'd0);
    chk("bp_valid_two", 64'(out_valid), 64'd1);
    chk("bp_hold_a", 64'(out_inst), 64'hAAAA_0001);
    tick();
    chk("bp_hold_a2", 64'(out_inst), 64'hAAAA_0001);
    chk("bp_ready_hold", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_then_b", 64'(out_inst), 64'hBBBB_0002);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Flush while full with an incoming word.
    send(32'hAAAA_0001, 32'h3004);
    tick();
    send(32'hBBBB_0002, 32'h3008);
    tick();
    chk("fl_ready_two", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_inst = 32'hCCCC_0003; in_pcplusfour = 32'h300C;
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_inst", 64'(out_inst), 64'(NOP));
    chk("fl_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("fl_stays_empty", 64'(out_valid), 64'd0);

    // Idle flush keeps the last loaded PC; out_ready toggles harmlessly.
    flush = 1'b1; out_ready = 1'b0;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    chk("idle_fl_valid", 64'(out_valid), 64'd0);
    chk("idle_fl_pc", 64'(out_pcplusfour), 64'h3004);
    tick();
    out_ready = 1'b0;
    chk("toggle_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-transfer, then accept on the first edge after release.
    send(32'hDDDD_0004, 32'h4004);
    tick();
    in_valid = 1'b0;
    chk("ar_loaded", 64'(out_inst), 64'hDDDD_0004);
    #3;
    Rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_inst", 64'(out_inst), 64'(NOP));
    chk("ar_pc", 64'(out_pcplusfour), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    chk("ar_bubble", 64'(bubble_cnt), 64'd0);
    tick();
    Rst_n = 1'b1;
    send(32'hEEEE_0005, 32'h5004);
    tick();
    in_valid = 1'b0;
    chk("ar_first_accept", 64'(out_inst), 64'hEEEE_0005);
    chk("ar_bubble_after", 64'(bubble_cnt), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("ar_drained", 64'(out_valid), 64'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
